// File: rtl/par_ser_hs.sv
// Parallel-to-serial link transmitter: valid/ready word intake, one-word holding
// buffer, selectable bit order, idle-word insertion or parked line when starved.
module par_ser_hs #(
  parameter int               WIDTH     = 10,
  parameter bit               MSB_FIRST = 1'b0,
  parameter bit               IDLE_EN   = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b0011111010)
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_frame,
  output logic             out_idle
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_WAIT, S_SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] buf_word;
  logic [CW-1:0]    cont;
  logic [CW-1:0]    bit_idx;
  logic             buf_full;
  logic             is_idle;
  logic             load;
  logic             bypass;
  logic             fill;

  // A load edge starts a new word; in S_WAIT every enabled edge is one.
  assign in_ready = !buf_full;
  assign load     = enable && ((state == S_WAIT) || (cont == CW'(WIDTH - 1)));
  assign bypass   = load && !buf_full && in_valid;
  assign fill     = !bypass && in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state    <= S_WAIT;
      cont     <= '0;
      sh       <= '0;
      buf_full <= 1'b0;
      is_idle  <= 1'b0;
    end else begin
      if (load) begin
        cont <= '0;
        if (buf_full) begin
          sh       <= buf_word;
          buf_full <= 1'b0;
          is_idle  <= 1'b0;
          state    <= S_SHIFT;
        end else if (in_valid) begin
          sh      <= in_data;
          is_idle <= 1'b0;
          state   <= S_SHIFT;
        end else if (IDLE_EN) begin
          sh      <= IDLE_WORD;
          is_idle <= 1'b1;
          state   <= S_SHIFT;
        end else begin
          is_idle <= 1'b0;
          state   <= S_WAIT;
        end
      end else if (enable) begin
        cont <= cont + CW'(1);
      end
      // Intake ignores enable; it only sets the flag when the buffer is empty,
      // so it never collides with the clear above.
      if (fill) buf_full <= 1'b1;
    end
  end

  // NOTE: the buffer payload has no reset; it is only ever read while
  // buf_full says it holds a word, and buf_full itself is reset.
  always_ff @(posedge reloj) begin
    if (fill) buf_word <= in_data;
  end

  assign bit_idx   = MSB_FIRST ? (CW'(WIDTH - 1) - cont) : cont;
  assign out       = (state == S_SHIFT) && sh[bit_idx];
  assign out_frame = (state == S_SHIFT) && (cont == '0);
  assign out_idle  = (state == S_SHIFT) && is_idle;

endmodule

// File: tb/tb_par_ser_hs.sv
// Scoreboard bench for par_ser_hs: LSB-first idle-inserting instance and an
// MSB-first parked-line instance, each checked cycle by cycle against a queue.
module tb_par_ser_hs;

  localparam logic [9:0] IDLE = 10'b0011111010;

  typedef struct packed {
    logic o;
    logic f;
    logic i;
  } exp_t;

  logic       reloj = 1'b0;
  logic       reset_a, enable_a, valid_a, ready_a, out_a, frame_a, idle_a;
  logic [9:0] data_a;
  logic       reset_b, enable_b, valid_b, ready_b, out_b, frame_b, idle_b;
  logic [9:0] data_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic check_en_a = 1'b0;
  logic check_en_b = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 reloj = ~reloj;

  par_ser_hs #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_EN(1'b1), .IDLE_WORD(IDLE)) dut_a (
    .reloj(reloj), .reset(reset_a), .enable(enable_a), .in_data(data_a),
    .in_valid(valid_a), .in_ready(ready_a), .out(out_a),
    .out_frame(frame_a), .out_idle(idle_a)
  );

  par_ser_hs #(.WIDTH(10), .MSB_FIRST(1'b1), .IDLE_EN(1'b0), .IDLE_WORD(IDLE)) dut_b (
    .reloj(reloj), .reset(reset_b), .enable(enable_b), .in_data(data_b),
    .in_valid(valid_b), .in_ready(ready_b), .out(out_b),
    .out_frame(frame_b), .out_idle(idle_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push_word_a(input logic [9:0] w, input logic idle, input int reps);
    for (int i = 0; i < 10; i++)
      for (int r = 0; r < reps; r++)
        q_a.push_back(exp_t'{o: w[i], f: (i == 0), i: idle});
  endtask

  task automatic push_zero_a(input int n);
    for (int k = 0; k < n; k++) q_a.push_back(exp_t'{o: 1'b0, f: 1'b0, i: 1'b0});
  endtask

  task automatic push_word_b(input logic [9:0] w);
    for (int i = 0; i < 10; i++)
      q_b.push_back(exp_t'{o: w[9-i], f: (i == 0), i: 1'b0});
  endtask

  task automatic push_zero_b(input int n);
    for (int k = 0; k < n; k++) q_b.push_back(exp_t'{o: 1'b0, f: 1'b0, i: 1'b0});
  endtask

  always @(negedge reloj) begin
    if (check_en_a) begin
      if (q_a.size() == 0) check("A_underflow", 32'd1, 32'd0);
      else begin
        e_a = q_a.pop_front();
        check("A_line", {29'd0, out_a, frame_a, idle_a}, {29'd0, e_a});
      end
    end
  end

  always @(negedge reloj) begin
    if (check_en_b) begin
      if (q_b.size() == 0) check("B_underflow", 32'd1, 32'd0);
      else begin
        e_b = q_b.pop_front();
        check("B_line", {29'd0, out_b, frame_b, idle_b}, {29'd0, e_b});
      end
    end
  end

  initial begin
    reset_a = 1'b1; enable_a = 1'b1; valid_a = 1'b0; data_a = '0;
    reset_b = 1'b1; enable_b = 1'b1; valid_b = 1'b0; data_b = '0;

    // ---------------- instance A: LSB first, idle insertion ----------------
    tick();
    reset_a = 1'b0;
    push_zero_a(1);
    check_en_a = 1'b1;
    check("A_rst_ready", {31'd0, ready_a}, 32'd1);

    push_word_a(IDLE, 1'b1, 1);
    push_word_a(IDLE, 1'b1, 1);
    run(20);

    // Bypass at a load edge, then a word offered one cycle later goes to buf.
    push_word_a(10'h2A5, 1'b0, 1);
    push_word_a(10'h155, 1'b0, 1);
    push_word_a(IDLE, 1'b1, 1);
    data_a = 10'h2A5; valid_a = 1'b1;
    tick();
    data_a = 10'h155; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    check("A_buf_ready_low", {31'd0, ready_a}, 32'd0);
    run(8);
    check("A_ready_hold", {31'd0, ready_a}, 32'd0);
    tick();
    check("A_ready_back", {31'd0, ready_a}, 32'd1);
    run(19);

    // Enable toggling: every bit held two cycles; word offered while enable low.
    push_word_a(10'h0F3, 1'b0, 2);
    push_word_a(10'h1C6, 1'b0, 2);
    push_word_a(IDLE, 1'b1, 1);
    for (int e = 51; e <= 90; e++) begin
      enable_a = (e % 2 == 1);
      valid_a  = (e == 51) || (e == 52);
      data_a   = (e == 51) ? 10'h0F3 : 10'h1C6;
      tick();
      if (e == 52) check("A_gate_buf_ready", {31'd0, ready_a}, 32'd0);
      if (e == 71) check("A_gate_ready_back", {31'd0, ready_a}, 32'd1);
    end
    enable_a = 1'b1; valid_a = 1'b0;
    run(10);

    // Reset at bit 4 of 2A5 with 155 buffered: both words are discarded.
    for (int i = 0; i < 5; i++) q_a.push_back(exp_t'{o: data_a_bit(i), f: (i == 0), i: 1'b0});
    push_zero_a(1);
    push_word_a(IDLE, 1'b1, 1);
    push_word_a(IDLE, 1'b1, 1);
    data_a = 10'h2A5; valid_a = 1'b1;
    tick();
    data_a = 10'h155; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    check("A_pre_reset_ready", {31'd0, ready_a}, 32'd0);
    run(3);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("A_mid_reset_ready", {31'd0, ready_a}, 32'd1);
    run(20);
    @(negedge reloj);
    #1;
    check_en_a = 1'b0;
    check("A_queue_empty", q_a.size(), 32'd0);

    // ---------------- instance B: MSB first, parked line ----------------
    tick();
    reset_b = 1'b0;
    push_zero_b(1);
    check_en_b = 1'b1;
    check("B_rst_ready", {31'd0, ready_b}, 32'd1);
    push_zero_b(15);
    run(15);

    push_word_b(10'h301);
    push_zero_b(5);
    push_word_b(10'h3FF);
    push_zero_b(5);
    data_b = 10'h301; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    check("B_bypass_ready", {31'd0, ready_b}, 32'd1);
    run(14);
    data_b = 10'h3FF; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    run(14);
    @(negedge reloj);
    #1;
    check_en_b = 1'b0;
    check("B_queue_empty", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic data_a_bit(input int i);
    logic [9:0] w;
    w = 10'h2A5;
    return w[i];
  endfunction

endmodule

// File: doc/par_ser_hs.md
# par_ser_hs

Parametrised parallel-to-serial transmitter for the serial link datapath: accepts WIDTH-bit words over a valid/ready handshake, buffers one word while the previous word shifts out, and emits one bit per enabled clock. Bit order is selectable. When no data is waiting, the block either inserts an idle word or parks the line low. Word-boundary and idle flags are provided for the matching receiver and for link monitoring.

## Interface
- WIDTH, 10, word width in bits; must be ≥ 2.
- MSB_FIRST, 0, 0 = bit 0 first on the line; 1 = bit WIDTH-1 first.
- IDLE_EN, 1, 1 = insert IDLE_WORD when starved; 0 = park the line low (no frames) when starved.
- IDLE_WORD, 10'b0011111010, filler word of WIDTH bits, sent when IDLE_EN = 1.

- reloj, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high; dominates all other inputs.
- enable, in, 1, bit-rate qualifier; when low, the shifter and bit counter freeze.
- in_data, in, WIDTH, parallel word.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block can take a word; combinational, equal to !buf_full.
- out, out, 1, serial bit.
- out_frame, out, 1, high while out carries the first bit of a word (data or idle).
- out_idle, out, 1, high for all WIDTH bits of an idle word.

## Operation
- State: shift register sh[WIDTH], bit counter cont (0..WIDTH-1, width $clog2(WIDTH)), holding buffer buf[WIDTH] with flag buf_full, flag is_idle, and a state register with two states.
- State S_WAIT: no word loaded. out = 0, out_frame = 0, out_idle = 0.
- State S_SHIFT: a word is loaded. out = sh[cont] when MSB_FIRST = 0, and sh[WIDTH-1-cont] when MSB_FIRST = 1.
- A load edge is any rising edge with enable = 1 where the state is S_WAIT, or the state is S_SHIFT and cont = WIDTH-1.
- At a load edge, the next word is chosen in this priority order:
  1. If buf_full: sh <= buf, buf_full <= 0, is_idle <= 0.
  2. Else if in_valid (in_ready is 1): sh <= in_data directly (bypass). This counts as the handshake; buf stays empty.
  3. Else if IDLE_EN = 1: sh <= IDLE_WORD, is_idle <= 1.
  4. Else: go to or stay in S_WAIT.
- After any load, the state is S_SHIFT and cont <= 0.
- On an enabled edge that is not a load edge: cont <= cont+1.
- Buffer fill: on any edge that is not a load-edge bypass, if in_valid && in_ready then buf <= in_data and buf_full <= 1. Buffer fill is independent of enable.
- While enable = 0, the handshake and buffer fill still operate. Outputs hold their values because sh, cont and the state are frozen.
- out_frame = (state == S_SHIFT) && (cont == 0).
- out_idle = (state == S_SHIFT) && is_idle.
- Simultaneous load edge, buf_full = 1 and in_valid = 1: in_ready is 0, so in_data is not taken. buf empties at that edge, and in_ready rises on the next cycle.

## Timing
- Reset values, on the edge after reset is sampled high:
  - state = S_WAIT, cont = 0, buf_full = 0, is_idle = 0, sh = 0.
  - out = 0, out_frame = 0, out_idle = 0, in_ready = 1.
- Reset mid-word discards both the shifting word and the buffered word. No partial word completes.
- The first enabled edge after reset is a load edge. With IDLE_EN = 1, the line therefore starts with an idle word if nothing is offered.
- Latency with empty buffer at a load edge: word bit 0 (or bit WIDTH-1 if MSB_FIRST) appears on out in the cycle after the accepting edge, with out_frame = 1.
- Latency with the word buffered: it starts on the cycle after the next load edge.
- Word period: exactly WIDTH enabled cycles. With a continuous source, the line carries back-to-back words with no gap bits.
- Sustained throughput: 1 word per WIDTH enabled cycles. in_ready is high for at most 1 of every WIDTH cycles once the buffer and shifter are both busy.
- Combinational paths: only buf_full → in_ready. out, out_frame and out_idle depend on registers only.

## Test plan
- Idle line: WIDTH = 10, IDLE_EN = 1, LSB-first, enable = 1, in_valid = 0 after reset → out repeats 0,1,0,1,1,1,1,1,0,0 every 10 cycles; out_frame pulses every 10th cycle; out_idle = 1 continuously.
- Bypass and buffering:
  - Offer 10'h2A5 at a load edge → bits 1,0,1,0,0,1,0,1,0,1 on the next 10 cycles, out_idle = 0.
  - Offer 10'h155 one cycle later → accepted into buf, in_ready drops, word follows with no gap, in_ready returns 1 at its load edge.
- MSB_FIRST = 1, word 10'h301 → out = 1,1,0,0,0,0,0,0,0,1.
- IDLE_EN = 0, no data → out = 0, out_frame = 0 indefinitely. Then offer 10'h3FF → ten 1s starting the next cycle, then back to S_WAIT.
- Enable gating: enable toggles 1,0,1,0 → each bit is held for 2 cycles. A word offered while enable = 0 fills buf; out_frame is not duplicated.
- Reset mid-operation: assert reset at bit 4 of 10'h2A5 while buf holds 10'h155 → next cycle all outputs are 0 and in_ready = 1. Neither word is ever transmitted afterward.
